// File: rtl/digital_stream_tx.sv
// Transmit end of the dCLK/dDAT/dFM telemetry link. Words pass through a one-deep holding
// register and are shifted out MSB first on a divided bit clock, zero-filled on underrun.
module digital_stream_tx #(
  parameter int unsigned HALF_PERIOD = 12,
  parameter int unsigned WORD_BITS   = 12,
  parameter int unsigned FRAME_WORDS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [WORD_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 dCLK,
  output logic                 dDAT,
  output logic                 dFM,
  output logic                 word_sent,
  output logic                 frame_start,
  output logic                 underrun,
  output logic [15:0]          underrun_count
);

  localparam int unsigned DivW  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned BitW  = $clog2(WORD_BITS + 1);
  localparam int unsigned WordW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [DivW-1:0]  DivLast  = DivW'(HALF_PERIOD - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WORD_BITS - 1);
  localparam logic [WordW-1:0] WordLast = WordW'(FRAME_WORDS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e               state_q;
  logic [DivW-1:0]      div_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [WordW-1:0]     word_cnt_q;
  logic [WORD_BITS-1:0] shift_q;
  logic [WORD_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 ready_q;
  logic                 dclk_q;
  logic                 dfm_q;
  logic                 in_word_q;
  logic                 word_sent_q;
  logic                 frame_start_q;
  logic                 underrun_q;
  logic [15:0]          underrun_cnt_q;

  logic tick, fall, boundary, do_load, take;

  // A word boundary is the falling event after the last bit, or the first falling event
  // after entering RUN when no word is in flight yet.
  always_comb begin
    tick     = (state_q == StRun) && (div_cnt_q == DivLast);
    fall     = tick && dclk_q;
    boundary = fall && (!in_word_q || (bit_cnt_q == '0));
    do_load  = boundary && enable;
    take     = data_valid && ready_q;
  end

  // A load always sees the pre-handshake holding state, so a same-cycle transfer is kept
  // for the following word.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    if (do_load) begin
      hold_full_d = 1'b0;
    end
    if (take) begin
      hold_full_d = 1'b1;
      hold_d      = data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      word_cnt_q     <= '0;
      shift_q        <= '0;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      ready_q        <= 1'b0;
      dclk_q         <= 1'b0;
      dfm_q          <= 1'b0;
      in_word_q      <= 1'b0;
      word_sent_q    <= 1'b0;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      word_sent_q   <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      hold_full_q   <= hold_full_d;
      hold_q        <= hold_d;
      ready_q       <= ~hold_full_d;

      unique case (state_q)
        StIdle: begin
          div_cnt_q <= '0;
          dclk_q    <= 1'b0;
          if (enable) begin
            state_q <= StRun;
          end
        end

        StRun: begin
          if (tick) begin
            div_cnt_q <= '0;
            dclk_q    <= ~dclk_q;
          end else begin
            div_cnt_q <= div_cnt_q + DivW'(1);
          end

          if (boundary) begin
            if (!enable) begin
              state_q    <= StIdle;
              in_word_q  <= 1'b0;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
              shift_q    <= '0;
              dfm_q      <= 1'b0;
            end else begin
              in_word_q     <= 1'b1;
              bit_cnt_q     <= BitLast;
              shift_q       <= hold_full_q ? hold_q : '0;
              dfm_q         <= (word_cnt_q == '0);
              word_sent_q   <= 1'b1;
              frame_start_q <= (word_cnt_q == '0);
              word_cnt_q    <= (word_cnt_q == WordLast) ? '0 : word_cnt_q + WordW'(1);
              if (!hold_full_q) begin
                underrun_q <= 1'b1;
                if (underrun_cnt_q != 16'hFFFF) begin
                  underrun_cnt_q <= underrun_cnt_q + 16'd1;
                end
              end
            end
          end else if (fall) begin
            shift_q   <= {shift_q[WORD_BITS-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q - BitW'(1);
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_ready     = ready_q;
  assign dCLK           = dclk_q;
  assign dDAT           = shift_q[WORD_BITS-1];
  assign dFM            = dfm_q;
  assign word_sent      = word_sent_q;
  assign frame_start    = frame_start_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_cnt_q;

endmodule

// File: tb/tb_digital_stream_tx.sv
// Bench for digital_stream_tx: expected words are queued as they are offered and checked
// bit-by-bit against dDAT/dFM sampled at each dCLK rising edge.
module tb_digital_stream_tx;

  localparam int unsigned HP = 2;
  localparam int unsigned WB = 12;
  localparam int unsigned FW = 4;
  localparam int WordClks = 2 * HP * WB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [WB-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready, dCLK, dDAT, dFM, word_sent, frame_start, underrun;
  logic [15:0]   underrun_count;

  typedef struct {
    logic [WB-1:0] word;
    logic          fm;
  } vec_t;

  vec_t exp_q[$];
  vec_t feed_tbl[8];

  int n_checks = 0;
  int n_fail = 0;
  int ws_cnt = 0;
  int fs_cnt = 0;
  int ur_cnt = 0;
  int words_done = 0;
  bit gap_check = 1'b0;

  always #5 clk = ~clk;

  digital_stream_tx #(
    .HALF_PERIOD(HP),
    .WORD_BITS  (WB),
    .FRAME_WORDS(FW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .dCLK          (dCLK),
    .dDAT          (dDAT),
    .dFM           (dFM),
    .word_sent     (word_sent),
    .frame_start   (frame_start),
    .underrun      (underrun),
    .underrun_count(underrun_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [WB-1:0] w, input logic fm);
    vec_t v;
    v.word = w;
    v.fm   = fm;
    exp_q.push_back(v);
  endtask

  // Reassembles each word from rising-edge samples and checks it against the queue head.
  task automatic monitor();
    logic          prev_clk = 1'b0;
    logic          coll = 1'b0;
    logic          fm_hi = 1'b0;
    logic          fm_lo = 1'b0;
    logic [WB-1:0] sh = '0;
    int            nb = 0;
    int            cyc = 0;
    int            last_ws = -1;
    vec_t          e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        coll = 1'b0;
        prev_clk = 1'b0;
        last_ws = -1;
        continue;
      end
      if (frame_start) begin
        fs_cnt++;
        check("frame_start_with_word_sent", word_sent, 1);
      end
      if (underrun) ur_cnt++;
      if (word_sent) begin
        ws_cnt++;
        if (coll) check("word_truncated_bits", nb, WB);
        if (gap_check && last_ws >= 0) check("word_gap_clks", cyc - last_ws, WordClks);
        last_ws = cyc;
        coll = 1'b1;
        nb = 0;
        fm_hi = 1'b0;
        fm_lo = 1'b0;
      end
      if (dCLK && !prev_clk && coll) begin
        sh = {sh[WB-2:0], dDAT};
        fm_hi |= dFM;
        fm_lo |= !dFM;
        nb++;
        if (nb == WB) begin
          coll = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_word", {20'd0, sh}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("word_data", sh, e.word);
            check("word_dfm", {fm_hi, fm_lo}, e.fm ? 2'b10 : 2'b01);
            words_done++;
          end
        end
      end
      prev_clk = dCLK;
    end
  endtask

  task automatic send_word(input logic [WB-1:0] w);
    data_in    = w;
    data_valid = 1'b1;
    for (int i = 0; i < 4 * WordClks && !data_ready; i++) @(negedge clk);
    check("ready_before_timeout", data_ready, 1);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < n * WordClks + 200 && words_done < n; i++) @(negedge clk);
    check("words_completed", words_done, n);
  endtask

  task automatic wait_ur(input int n);
    for (int i = 0; i < 4 * WordClks && ur_cnt < n; i++) @(negedge clk);
    check("underrun_pulses", ur_cnt, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    data_valid = 1'b0;
    exp_q.delete();
    ws_cnt = 0;
    fs_cnt = 0;
    ur_cnt = 0;
    words_done = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int c;
    int ws0;
    logic any_hi;
    logic [15:0] sat_exp[4];

    feed_tbl[0] = '{12'h001, 1'b1};
    feed_tbl[1] = '{12'h002, 1'b0};
    feed_tbl[2] = '{12'h003, 1'b0};
    feed_tbl[3] = '{12'h004, 1'b0};
    feed_tbl[4] = '{12'h005, 1'b1};
    feed_tbl[5] = '{12'h006, 1'b0};
    feed_tbl[6] = '{12'h007, 1'b0};
    feed_tbl[7] = '{12'h008, 1'b0};
    sat_exp[0] = 16'hFFFE;
    sat_exp[1] = 16'hFFFF;
    sat_exp[2] = 16'hFFFF;
    sat_exp[3] = 16'hFFFF;

    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state and first word 0xA5C.
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_flags", {dCLK, dDAT, dFM, data_ready, word_sent, frame_start, underrun}, 0);
    check("reset_underrun_count", underrun_count, 0);
    enable = 1'b1;
    data_in = 12'hA5C;
    data_valid = 1'b1;
    push_exp(12'hA5C, 1'b1);
    rst = 1'b0;
    check("ready_low_at_release", data_ready, 0);
    @(negedge clk);
    check("ready_after_release", data_ready, 1);
    @(negedge clk);
    check("accepted_one_cycle", data_ready, 0);
    data_valid = 1'b0;
    c = 2;
    while (!word_sent && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("first_load_cycle", c, 5);
    wait_words(1);
    check("t1_word_sent", ws_cnt, 1);
    check("t1_frame_start", fs_cnt, 1);
    check("t1_underruns", ur_cnt, 0);

    // Continuous feed from the table.
    do_reset();
    gap_check = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_exp(feed_tbl[i].word, feed_tbl[i].fm);
      send_word(feed_tbl[i].word);
    end
    wait_words(8);
    check("t2_frame_start", fs_cnt, 2);
    check("t2_word_sent", ws_cnt, 8);
    check("t2_underruns", ur_cnt, 0);
    check("t2_underrun_count", underrun_count, 0);

    // Three starved slots, then a word in slot 3.
    do_reset();
    push_exp(12'h000, 1'b1);
    push_exp(12'h000, 1'b0);
    push_exp(12'h000, 1'b0);
    wait_ur(3);
    push_exp(12'h7FF, 1'b0);
    send_word(12'h7FF);
    wait_words(4);
    check("t3_underruns", ur_cnt, 3);
    check("t3_underrun_count", underrun_count, 3);
    check("t3_word_sent", ws_cnt, 4);

    // Asynchronous reset in the middle of 0xFFF.
    push_exp(12'hFFF, 1'b1);
    send_word(12'hFFF);
    for (int i = 0; i < 200 && ws_cnt < 5; i++) @(negedge clk);
    check("t4_fff_loaded", ws_cnt, 5);
    repeat (24) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_flags", {dCLK, dDAT, dFM, data_ready, word_sent, frame_start, underrun}, 0);
    check("async_reset_count", underrun_count, 0);
    exp_q.delete();
    ws_cnt = 0;
    fs_cnt = 0;
    ur_cnt = 0;
    words_done = 0;
    @(negedge clk);
    rst = 1'b0;
    push_exp(12'h123, 1'b1);
    send_word(12'h123);
    wait_words(1);
    check("t4_underrun_count", underrun_count, 0);
    check("t4_frame_start", fs_cnt, 1);

    // Drop enable during bit 2; the word completes, then the link idles.
    gap_check = 1'b0;
    push_exp(12'h3C3, 1'b0);
    send_word(12'h3C3);
    for (int i = 0; i < 200 && ws_cnt < 2; i++) @(negedge clk);
    check("t5_word_loaded", ws_cnt, 2);
    repeat (37) @(negedge clk);
    enable = 1'b0;
    wait_words(2);
    repeat (4) @(negedge clk);
    ws0 = ws_cnt;
    any_hi = 1'b0;
    repeat (60) begin
      @(negedge clk);
      any_hi |= dCLK | dDAT | dFM;
    end
    check("idle_outputs_low", any_hi, 0);
    check("idle_no_load", ws_cnt, ws0);
    check("idle_no_underrun", ur_cnt, 0);
    push_exp(12'h5A5, 1'b1);
    enable = 1'b1;
    send_word(12'h5A5);
    wait_words(3);
    check("t5_restart_frame_start", fs_cnt, 2);

    // Saturation: preload the counter near the top, then keep starving the link.
    push_exp(12'h000, 1'b0);
    push_exp(12'h000, 1'b0);
    push_exp(12'h000, 1'b0);
    push_exp(12'h000, 1'b1);
    push_exp(12'h000, 1'b0);
    push_exp(12'h000, 1'b0);
    push_exp(12'h000, 1'b0);
    push_exp(12'h000, 1'b1);
    wait_ur(1);
    @(negedge clk);
    force dut.underrun_cnt_q = 16'hFFFD;
    @(negedge clk);
    release dut.underrun_cnt_q;
    @(negedge clk);
    check("sat_preload", underrun_count, 16'hFFFD);
    for (int k = 0; k < 4; k++) begin
      wait_ur(2 + k);
      check("sat_count", underrun_count, sat_exp[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digital_stream_tx.md
Name: digital_stream_tx

Overview:
- Transmit end of the three-wire digital telemetry link (dCLK / dDAT / dFM) that the digital receiver front-end samples.
- Accepts 12-bit words over a valid/ready handshake, serializes them MSB-first, and generates the bit clock by division of the system clock.
- Raises dFM for the whole first word of every frame.
- Substitutes zero words when no data is ready at a word boundary, mirroring the zero-fill behaviour on the receive side.
- Used as a board-level stream source and as the stimulus generator for receiver benches.

Parameters:
- HALF_PERIOD, 12: clk cycles per dCLK half-period (min 2).
- WORD_BITS, 12: bits per word.
- FRAME_WORDS, 16: words per frame (min 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  stream run enable.
- data_in  in  WORD_BITS  word to send.
- data_valid  in  1  data_in valid.
- data_ready  out  1  holding register empty; transfer occurs when data_valid && data_ready.
- dCLK  out  1  generated bit clock.
- dDAT  out  1  serial data, MSB first.
- dFM  out  1  frame marker.
- word_sent  out  1  one-clk pulse when a word is loaded into the shifter.
- frame_start  out  1  one-clk pulse when word 0 of a frame is loaded.
- underrun  out  1  one-clk pulse when a zero word is substituted.
- underrun_count  out  16  saturating count of substituted words.

Behaviour:
- Reset (async, any time including mid-word): dCLK=0, dDAT=0, dFM=0, data_ready=0, word_sent=frame_start=underrun=0, underrun_count=0. Divider, bit counter, word counter and holding register are cleared; the holding register is empty. Next word after release is word 0 of a new frame.
- data_ready = ~rst && holding empty. It is registered and goes 1 on the first clk after reset release. Handshake transfer writes the holding register; data_ready drops the next cycle.
- Divider: div_cnt counts 0..HALF_PERIOD-1. Each time div_cnt == HALF_PERIOD-1 an edge event occurs: dCLK toggles and div_cnt returns to 0. dCLK starts low, so the first event is a rising edge.
- dDAT and dFM change only on falling events (dCLK 1->0), so they are stable around each rising edge, where the receiver samples.
- States:
  - IDLE: enable=0. dCLK held 0, divider held at 0, dDAT=0, dFM=0.
  - RUN: entered when enable=1. The first falling event after entry loads word 0.
  - Dropping enable takes effect only after the falling event that would start the next word; the word in progress always completes. On that event: IDLE, dDAT=0, dFM=0, word counter reset to 0.
- Word load, at the falling event preceding bit WORD_BITS-1:
  - If the holding register is full, load it into the shifter and mark holding empty.
  - Otherwise load all zeros, pulse underrun, and increment underrun_count (saturates at 0xFFFF).
  - word_sent pulses on the load cycle. frame_start pulses as well if word_cnt == 0.
  - dFM = (word_cnt == 0) for all WORD_BITS bit periods of that word.
  - word_cnt wraps from FRAME_WORDS-1 to 0.
- A handshake in the same cycle as a load that finds holding empty is not used for that word: the zero word is sent, and the incoming word is stored for the next word.
- Bits: each subsequent falling event shifts the next bit. One word = WORD_BITS dCLK periods = 2*HALF_PERIOD*WORD_BITS clk. Back-to-back words with no gap.
- All outputs are registered.

Test Plan:
- HALF_PERIOD=2, FRAME_WORDS=4. rst released, enable=1, present 0xA5C with valid held. Required: accepted 1 cycle after ready. The first falling event loads it. dDAT sampled at successive dCLK rising edges = 1,0,1,0,0,1,0,1,1,1,0,0. dFM=1 for those 12 periods. frame_start and word_sent each pulse once.
- Continuous feed of 0x001..0x008. Required: dFM high only during 0x001 and 0x005. No idle gap between words. frame_start pulses exactly twice. underrun_count=0.
- No data_valid for 3 word slots after start. Required: three zero words with dFM on the first. underrun pulses 3 times. underrun_count=3. Then supply 0x7FF: sent in the next slot as word 3.
- Assert rst mid-word (bit 5 of 0xFFF). Required: all outputs 0 immediately, not on a clock edge. After release, the next word loaded carries dFM=1 and underrun_count=0.
- Drop enable during bit 2 of a word. Required: the word completes all 12 bits, then dCLK stays 0 and dFM/dDAT=0. Re-enabling restarts with dFM=1 (word 0).
- Force 65536 underruns. Required: underrun_count saturates at 0xFFFF, and the underrun pulse continues on each substituted word.
